vga_pixel_write_arbiter: RTL and testbench
==========================================

// Module: vga_pixel_write_arbiter
// PURPOSE
//  Multi-channel successor to the single-engine pixel buffer write control.
//  Arbitrates pixel-write requests from N_CH fractal engines (round-robin) into one pixel-buffer SRAM port.
//  Generates timed OE_N/WE_N with parametrised write-pulse and recovery lengths, and yields to the VGA scan-out reader.
//  Returns a per-channel one-cycle done_draw pulse. Sits between the fractal engines and the pixel-buffer SRAM.
// PARAMETERS
//  N_CH        4   number of requesting engine channels (>=1)
//  ADDR_W      20  pixel address width
//  DATA_W      16  pixel colour width
//  WE_CYCLES   2   cycles WE_N is held low per write (>=1)
//  REC_CYCLES  1   cycles WE_N held high after write before next access (>=0)
// PORTS
//  clk        in   1             system clock, all logic on rising edge
//  reset      in   1             asynchronous, active-high reset
//  draw       in   N_CH          per-channel write request, level; held until done_draw of that channel
//  addr_in    in   N_CH*ADDR_W   per-channel pixel address, channel i at [i*ADDR_W +: ADDR_W]
//  data_in    in   N_CH*DATA_W   per-channel pixel colour, channel i at [i*DATA_W +: DATA_W]
//  vga_busy   in   1             scan-out reader owns SRAM; no new write may start
//  done_draw  out  N_CH          one-cycle pulse: channel's pixel written
//  busy       out  1             high while a write transaction is in flight (SETUP/WRITE/RECOVER)
//  sram_addr  out  ADDR_W        latched address of granted channel
//  sram_data  out  DATA_W        latched colour of granted channel
//  OE_N       out  1             SRAM output enable, active-low
//  WE_N       out  1             SRAM write enable, active-low
// BEHAVIOUR
//  - All outputs are registered. Reset (async) forces:
//    - state=IDLE, WE_N=1, OE_N=0, busy=0, done_draw=0, sram_addr=0, sram_data=0, rr_ptr=0.
//  - FSM states: IDLE, SETUP, WRITE, RECOVER. One down-counter, width $clog2(max(WE_CYCLES,REC_CYCLES)+1).
//  - IDLE:
//    - OE_N=0, WE_N=1, busy=0.
//    - Candidate set = draw masked by the channel completed in the previous cycle (see done rule).
//    - If the set is non-empty and vga_busy=0: grant the first requester searching rr_ptr, rr_ptr+1, ... (mod N_CH).
//    - On grant: latch that channel's addr/data into sram_addr/sram_data; rr_ptr <= grant+1 (mod N_CH); go to SETUP.
//    - If vga_busy=1: remain in IDLE. Requests stay pending; none are lost.
//  - SETUP: exactly 1 cycle. OE_N=1, WE_N=1, busy=1, address/data stable. Next: WRITE, counter=WE_CYCLES.
//  - WRITE: WE_N=0, OE_N=1 for exactly WE_CYCLES cycles. Next: RECOVER (REC_CYCLES>0) or IDLE (REC_CYCLES=0).
//  - RECOVER: WE_N=1, OE_N=1 for exactly REC_CYCLES cycles, then IDLE.
//  - sram_addr/sram_data stay constant from SETUP through the last WRITE/RECOVER cycle.
//  - vga_busy asserted mid-transaction is ignored: the in-flight write always completes.
//  - done rule:
//    - done_draw[g] is high for exactly the first IDLE cycle after transaction g.
//    - Channel g is masked from arbitration in that cycle, so a late-dropped draw is never re-granted.
//    - A new grant to another channel may occur in that same cycle.
//  - Latency, defaults, measured from cycle 0 = draw seen in IDLE with vga_busy=0:
//    - cycle 1 SETUP; WE_N=0 in cycles 2-3; RECOVER cycle 4; done_draw cycle 5.
//    - In general, done_draw occurs at cycle 2+WE_CYCLES+REC_CYCLES.
//  - Back-to-back writes: minimum period 2+WE_CYCLES+REC_CYCLES cycles per pixel, because grant occurs in the done cycle.
//  - Reset mid-transaction: WE_N returns to 1 asynchronously. The write is abandoned, no done_draw, rr_ptr=0.
//  - addr_in/data_in of non-granted channels are don't-care. A draw that falls without a done is undefined use.
// TESTING
//  1. Single channel: draw[0]=1, addr=0x00ABC, data=0x7E0 -> SETUP c1; WE_N low c2-3 with sram_addr=0x00ABC, sram_data=0x7E0; done_draw=4'b0001 at c5.
//  2. All four draw at c0 -> grants in order 0,1,2,3; done pulses at c5,c10,c15,c20; WE_N never low in SETUP/RECOVER.
//  3. Ch1 draw held continuously; ch3 requests at c2 -> ch3 granted at c5 (done cycle of ch1, ch1 masked); ch1 is next after ch3.
//  4. vga_busy=1 from c0 to c6 with draw[2]=1 -> no SETUP before c7; vga_busy rising during WRITE -> write still completes.
//  5. reset pulse while WE_N=0 (c2) -> WE_N=1 and OE_N=0 before the next clock edge; no done_draw; next grant restarts from channel 0.
//  6. REC_CYCLES=0, WE_CYCLES=1 build: back-to-back single-channel writes -> done every 3 cycles; WE_N low one cycle each.

Source files
------------

// File: rtl/vga_pixel_write_arbiter.sv
// vga_pixel_write_arbiter: round-robin pixel-write arbiter driving one SRAM port with timed OE_N/WE_N.
// Revision: 1.0
`default_nettype none

module vga_pixel_write_arbiter #(
  parameter int N_CH       = 4,
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 16,
  parameter int WE_CYCLES  = 2,
  parameter int REC_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_CH-1:0]          draw,
  input  logic [N_CH*ADDR_W-1:0]   addr_in,
  input  logic [N_CH*DATA_W-1:0]   data_in,
  input  logic                     vga_busy,
  output logic [N_CH-1:0]          done_draw,
  output logic                     busy,
  output logic [ADDR_W-1:0]        sram_addr,
  output logic [DATA_W-1:0]        sram_data,
  output logic                     OE_N,
  output logic                     WE_N
);

  localparam int MAX_CYC = (WE_CYCLES > REC_CYCLES) ? WE_CYCLES : REC_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam int PTR_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [PTR_W:0]   N_CH_W  = (PTR_W+1)'(N_CH);
  localparam logic [PTR_W-1:0] LAST_CH = PTR_W'(N_CH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, SETUP, WRITE, RECOVER} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [PTR_W-1:0]  rr_ptr, rr_ptr_nxt;
  logic [PTR_W-1:0]  cur_ch, cur_ch_nxt;
  logic [PTR_W-1:0]  grant;
  logic              grant_vld;
  logic [PTR_W:0]    scan_idx;
  logic [N_CH-1:0]   cand;
  logic [N_CH-1:0]   done_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic [ADDR_W-1:0] addr_arr [N_CH];
  logic [DATA_W-1:0] data_arr [N_CH];

  for (genvar i = 0; i < N_CH; i++) begin : g_unpack
    assign addr_arr[i] = addr_in[i*ADDR_W +: ADDR_W];
    assign data_arr[i] = data_in[i*DATA_W +: DATA_W];
  end

  // The channel finishing this cycle is masked so a late-dropped draw cannot be re-granted.
  always_comb begin
    cand      = draw & ~done_draw;
    grant     = '0;
    grant_vld = 1'b0;
    scan_idx  = '0;
    for (int k = 0; k < N_CH; k++) begin
      scan_idx = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (scan_idx >= N_CH_W) scan_idx = scan_idx - N_CH_W;
      if (!grant_vld && cand[scan_idx[PTR_W-1:0]]) begin
        grant_vld = 1'b1;
        grant     = scan_idx[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    rr_ptr_nxt = rr_ptr;
    cur_ch_nxt = cur_ch;
    addr_nxt   = sram_addr;
    data_nxt   = sram_data;
    done_nxt   = '0;
    case (state)
      IDLE: begin
        if (grant_vld && !vga_busy) begin
          state_nxt  = SETUP;
          cur_ch_nxt = grant;
          rr_ptr_nxt = (grant == LAST_CH) ? '0 : grant + 1'b1;
          addr_nxt   = addr_arr[grant];
          data_nxt   = data_arr[grant];
        end
      end
      SETUP: begin
        state_nxt = WRITE;
        cnt_nxt   = CNT_W'(WE_CYCLES);
      end
      WRITE: begin
        if (cnt == CNT_ONE) begin
          if (REC_CYCLES > 0) begin
            state_nxt = RECOVER;
            cnt_nxt   = CNT_W'(REC_CYCLES);
          end else begin
            state_nxt        = IDLE;
            done_nxt[cur_ch] = 1'b1;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      RECOVER: begin
        if (cnt == CNT_ONE) begin
          state_nxt        = IDLE;
          done_nxt[cur_ch] = 1'b1;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they align exactly with the state they belong to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      rr_ptr    <= '0;
      cur_ch    <= '0;
      done_draw <= '0;
      busy      <= 1'b0;
      sram_addr <= '0;
      sram_data <= '0;
      OE_N      <= 1'b0;
      WE_N      <= 1'b1;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      rr_ptr    <= rr_ptr_nxt;
      cur_ch    <= cur_ch_nxt;
      done_draw <= done_nxt;
      busy      <= (state_nxt != IDLE);
      sram_addr <= addr_nxt;
      sram_data <= data_nxt;
      OE_N      <= (state_nxt != IDLE);
      WE_N      <= (state_nxt != WRITE);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_pixel_write_arbiter.sv
// tb_vga_pixel_write_arbiter: directed stimulus with a transaction-timeline model and literal anchors.
`default_nettype none

module tb_vga_pixel_write_arbiter;

  localparam int N     = 4;
  localparam int AW    = 20;
  localparam int DW    = 16;
  localparam int WE    = 2;
  localparam int REC   = 1;
  localparam int TOTAL = 2 + WE + REC;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    draw;
  logic [N*AW-1:0] addr_in;
  logic [N*DW-1:0] data_in;
  logic            vga_busy;
  logic [N-1:0]    done_draw;
  logic            busy;
  logic [AW-1:0]   sram_addr;
  logic [DW-1:0]   sram_data;
  logic            OE_N, WE_N;

  logic [1:0]      draw2;
  logic [2*AW-1:0] addr_in2;
  logic [2*DW-1:0] data_in2;
  logic [1:0]      done2;
  logic            busy2;
  logic [AW-1:0]   sram_addr2;
  logic [DW-1:0]   sram_data2;
  logic            oe2, we2;

  vga_pixel_write_arbiter #(.N_CH(N), .ADDR_W(AW), .DATA_W(DW), .WE_CYCLES(WE), .REC_CYCLES(REC)) dut (
    .clk(clk), .reset(reset), .draw(draw), .addr_in(addr_in), .data_in(data_in),
    .vga_busy(vga_busy), .done_draw(done_draw), .busy(busy), .sram_addr(sram_addr),
    .sram_data(sram_data), .OE_N(OE_N), .WE_N(WE_N));

  vga_pixel_write_arbiter #(.N_CH(2), .ADDR_W(AW), .DATA_W(DW), .WE_CYCLES(1), .REC_CYCLES(0)) dut2 (
    .clk(clk), .reset(reset), .draw(draw2), .addr_in(addr_in2), .data_in(data_in2),
    .vga_busy(1'b0), .done_draw(done2), .busy(busy2), .sram_addr(sram_addr2),
    .sram_data(sram_data2), .OE_N(oe2), .WE_N(we2));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_ph counts cycles since grant (0 = idle); outputs follow from that position alone.
  int            m_ph = 0;
  int            m_ch = 0;
  int            m_rr = 0;
  logic [N-1:0]  m_done = '0;
  logic [N-1:0]  m_cand = '0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ph = 0; m_rr = 0; m_done = '0; m_addr = '0; m_data = '0;
    end else if (m_ph == 0) begin
      m_cand = draw & ~m_done;
      m_done = '0;
      if (m_cand != '0 && !vga_busy) begin
        for (int k = 0; k < N; k++) begin
          if (m_cand[(m_rr + k) % N]) begin
            m_ch = (m_rr + k) % N;
            break;
          end
        end
        m_rr   = (m_ch + 1) % N;
        m_ph   = 1;
        m_addr = addr_in[m_ch*AW +: AW];
        m_data = data_in[m_ch*DW +: DW];
      end
    end else begin
      m_ph++;
      if (m_ph == TOTAL) begin
        m_ph   = 0;
        m_done = N'(1) << m_ch;
      end
    end
  end

  always @(negedge clk) begin
    chk("m_done_draw", 32'(done_draw), 32'(m_done));
    chk("m_busy", 32'(busy), 32'(m_ph != 0));
    chk("m_OE_N", 32'(OE_N), 32'(m_ph != 0));
    chk("m_WE_N", 32'(WE_N), 32'(!(m_ph >= 2 && m_ph <= 1 + WE)));
    chk("m_sram_addr", 32'(sram_addr), 32'(m_addr));
    chk("m_sram_data", 32'(sram_data), 32'(m_data));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic settle(input int maxc);
    for (int c = 0; c < maxc; c++) begin
      tick();
      draw = draw & ~done_draw;
      if (draw == '0 && !busy && done_draw == '0) return;
    end
    checks++;
    errors++;
    $display("FAIL settle_timeout: still busy after %0d cycles", maxc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; draw = '0; vga_busy = 1'b0; draw2 = '0;
    addr_in = {20'h80001, 20'hFFFFF, 20'h12345, 20'h00ABC};
    data_in = {16'hFFFF, 16'h001F, 16'hF800, 16'h07E0};
    addr_in2 = {20'h22222, 20'h11111};
    data_in2 = {16'h2222, 16'h1111};
    tick(); tick();
    chk("rst_WE_N", 32'(WE_N), 32'd1);
    chk("rst_OE_N", 32'(OE_N), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done_draw), 32'd0);
    chk("rst_addr", 32'(sram_addr), 32'd0);
    reset = 1'b0;
    tick();

    // Single channel
    draw = 4'b0001;
    tick();
    chk("t1_c1_busy", 32'(busy), 32'd1);
    chk("t1_c1_WE_N", 32'(WE_N), 32'd1);
    chk("t1_c1_OE_N", 32'(OE_N), 32'd1);
    tick();
    chk("t1_c2_WE_N", 32'(WE_N), 32'd0);
    chk("t1_c2_addr", 32'(sram_addr), 32'h00ABC);
    chk("t1_c2_data", 32'(sram_data), 32'h07E0);
    tick();
    chk("t1_c3_WE_N", 32'(WE_N), 32'd0);
    tick();
    chk("t1_c4_WE_N", 32'(WE_N), 32'd1);
    chk("t1_c4_busy", 32'(busy), 32'd1);
    tick();
    chk("t1_c5_done", 32'(done_draw), 32'b0001);
    chk("t1_c5_busy", 32'(busy), 32'd0);
    draw = '0;
    settle(10);
    do_reset();

    // All four channels at once
    draw = 4'b1111;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk("t2_done", 32'(done_draw), (k % 5 == 0) ? (32'd1 << (k/5 - 1)) : 32'd0);
      if (k % 5 == 1) chk("t2_addr", 32'(sram_addr), 32'(addr_in[((k-1)/5)*AW +: AW]));
      draw = draw & ~done_draw;
    end
    settle(10);
    do_reset();

    // Held ch1 is masked in its done cycle; ch3 wins, then ch1 again
    draw = 4'b0010;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (k == 2) draw = draw | 4'b1000;
      if (k == 5) chk("t3_done1", 32'(done_draw), 32'b0010);
      if (k == 6) chk("t3_grant3", 32'(sram_addr), 32'h80001);
      if (k == 10) begin
        chk("t3_done3", 32'(done_draw), 32'b1000);
        draw = draw & ~4'b1000;
      end
      if (k == 11) chk("t3_grant1", 32'(sram_addr), 32'h12345);
      if (k == 15) begin
        chk("t3_done1b", 32'(done_draw), 32'b0010);
        draw = '0;
      end
    end
    settle(10);
    do_reset();

    // vga_busy holds off the start but not an in-flight write
    vga_busy = 1'b1;
    draw = 4'b0100;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk("t4_hold_busy", 32'(busy), 32'd0);
    end
    vga_busy = 1'b0;
    tick();
    chk("t4_c8_busy", 32'(busy), 32'd1);
    tick();
    chk("t4_c9_WE_N", 32'(WE_N), 32'd0);
    vga_busy = 1'b1;
    tick(); tick(); tick();
    chk("t4_c12_done", 32'(done_draw), 32'b0100);
    draw = '0;
    vga_busy = 1'b0;
    settle(10);
    do_reset();

    // Reset in the middle of a write
    draw = 4'b0001;
    tick(); tick();
    chk("t5_c2_WE_N", 32'(WE_N), 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("t5_async_WE_N", 32'(WE_N), 32'd1);
    chk("t5_async_OE_N", 32'(OE_N), 32'd0);
    chk("t5_async_busy", 32'(busy), 32'd0);
    #2 reset = 1'b0;
    draw = 4'b0011;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) chk("t5_restart_ch0", 32'(sram_addr), 32'h00ABC);
      chk("t5_done", 32'(done_draw), (k == 5) ? 32'b0001 : (k == 10) ? 32'b0010 : 32'd0);
      draw = draw & ~done_draw;
    end
    settle(10);

    // WE_CYCLES=1, REC_CYCLES=0: back-to-back writes every 3 cycles
    draw2 = 2'b11;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("t6_WE_N", 32'(we2), (k % 3 == 2) ? 32'd0 : 32'd1);
      chk("t6_done", 32'(done2),
          (k % 3 == 0) ? (((k/3) % 2 == 1) ? 32'b01 : 32'b10) : 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
